// File: rtl/if_id_buffer.sv
// ---------------------------------------------------------------------------
// if_id_buffer
//   Two-entry skid buffer at the IF/ID boundary of the pipelined RV32I core.
//   Fetch pushes {pc, instr} words through a valid/ready handshake. Decode
//   sees the oldest word on d_pc_o/d_instr_o. f_ready_o is computed from
//   registered occupancy only, so there is no combinational path from
//   d_ready_i or flush_i back to fetch. flush_i empties the buffer on a taken
//   branch or jump.
//
// Ports
//   clk_i      clock, rising edge
//   rst_i      asynchronous reset, active low
//   flush_i    discard all buffered words and any concurrent push
//   f_valid_i  fetch presents a word
//   f_ready_o  buffer can accept a word this cycle
//   f_pc_i     PC of the fetched word
//   f_instr_i  fetched instruction
//   d_valid_o  head entry valid for decode
//   d_ready_i  decode consumes the head this cycle
//   d_pc_o     PC of the head entry
//   d_instr_o  instruction of the head entry, NOP_INSTR when empty
//   count_o    occupancy, 0..2
// ---------------------------------------------------------------------------
module if_id_buffer #(
    parameter int          XLEN      = 32,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            flush_i,
    input  logic            f_valid_i,
    output logic            f_ready_o,
    input  logic [XLEN-1:0] f_pc_i,
    input  logic [XLEN-1:0] f_instr_i,
    output logic            d_valid_o,
    input  logic            d_ready_i,
    output logic [XLEN-1:0] d_pc_o,
    output logic [XLEN-1:0] d_instr_o,
    output logic [1:0]      count_o
);

    localparam logic [1:0] EMPTY = 2'd0;
    localparam logic [1:0] ONE   = 2'd1;
    localparam logic [1:0] FULL  = 2'd2;

    localparam logic [XLEN-1:0] NOP_W = XLEN'(NOP_INSTR);

    logic [1:0]      count_q, count_d;
    logic [XLEN-1:0] head_pc_q, head_pc_d;
    logic [XLEN-1:0] head_instr_q, head_instr_d;
    logic [XLEN-1:0] tail_pc_q, tail_pc_d;
    logic [XLEN-1:0] tail_instr_q, tail_instr_d;

    logic push, pop;

    // Handshake flags are derived from registered state only.
    assign f_ready_o = (count_q != FULL);
    assign d_valid_o = (count_q != EMPTY);
    assign push      = f_valid_i & f_ready_o;
    assign pop       = d_valid_o & d_ready_i;

    // The head instruction register holds NOP_INSTR whenever the buffer is
    // empty, so d_instr_o comes straight from a flop. That keeps it
    // glitch-free for the immediate generator and the control decoder.
    assign d_pc_o    = head_pc_q;
    assign d_instr_o = head_instr_q;
    assign count_o   = count_q;

    always_comb begin
        count_d      = count_q;
        head_pc_d    = head_pc_q;
        head_instr_d = head_instr_q;
        tail_pc_d    = tail_pc_q;
        tail_instr_d = tail_instr_q;

        if (flush_i) begin
            // Squash everything. Concurrent push and pop have no effect.
            count_d      = EMPTY;
            head_instr_d = NOP_W;
        end else begin
            case (count_q)
                EMPTY: begin
                    if (push) begin
                        count_d      = ONE;
                        head_pc_d    = f_pc_i;
                        head_instr_d = f_instr_i;
                    end
                end
                ONE: begin
                    if (push && pop) begin
                        // The head retires and the new word replaces it.
                        head_pc_d    = f_pc_i;
                        head_instr_d = f_instr_i;
                    end else if (push) begin
                        count_d      = FULL;
                        tail_pc_d    = f_pc_i;
                        tail_instr_d = f_instr_i;
                    end else if (pop) begin
                        count_d      = EMPTY;
                        head_instr_d = NOP_W;
                    end
                end
                FULL: begin
                    // Push is impossible here because f_ready_o is low.
                    if (pop) begin
                        count_d      = ONE;
                        head_pc_d    = tail_pc_q;
                        head_instr_d = tail_instr_q;
                    end
                end
                default: begin
                    count_d      = EMPTY;
                    head_instr_d = NOP_W;
                end
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            count_q      <= EMPTY;
            head_pc_q    <= '0;
            head_instr_q <= NOP_W;
        end else begin
            count_q      <= count_d;
            head_pc_q    <= head_pc_d;
            head_instr_q <= head_instr_d;
        end
    end

    // The second slot is only read when count_q is FULL, so it needs no reset.
    always_ff @(posedge clk_i) begin
        tail_pc_q    <= tail_pc_d;
        tail_instr_q <= tail_instr_d;
    end

endmodule

// File: tb/tb_if_id_buffer.sv
module tb_if_id_buffer;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        flush_i;
    logic        f_valid_i;
    logic        f_ready_o;
    logic [31:0] f_pc_i;
    logic [31:0] f_instr_i;
    logic        d_valid_o;
    logic        d_ready_i;
    logic [31:0] d_pc_o;
    logic [31:0] d_instr_o;
    logic [1:0]  count_o;

    int checks = 0;
    int errors = 0;

    if_id_buffer dut (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .flush_i  (flush_i),
        .f_valid_i(f_valid_i),
        .f_ready_o(f_ready_o),
        .f_pc_i   (f_pc_i),
        .f_instr_i(f_instr_i),
        .d_valid_o(d_valid_o),
        .d_ready_i(d_ready_i),
        .d_pc_o   (d_pc_o),
        .d_instr_o(d_instr_o),
        .count_o  (count_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance one rising edge and settle past it.
    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    function automatic logic [31:0] ins(input logic [31:0] pc);
        return pc ^ 32'hA5C3_0000;
    endfunction

    task automatic drive(input logic v, input logic [31:0] pc, input logic rdy, input logic fl);
        f_valid_i = v;
        f_pc_i    = pc;
        f_instr_i = ins(pc);
        d_ready_i = rdy;
        flush_i   = fl;
    endtask

    logic [63:0] q[$];

    initial begin
        // Reset, held low with random inputs across clock edges
        rst_i = 1'b0;
        for (int i = 0; i < 4; i++) begin
            drive(1'($urandom), $urandom, 1'($urandom), 1'($urandom));
            step();
        end
        chk("rst_valid", 32'(d_valid_o), 32'd0);
        chk("rst_instr", d_instr_o, NOP);
        chk("rst_count", 32'(count_o), 32'd0);
        chk("rst_ready", 32'(f_ready_o), 32'd1);
        chk("rst_pc",    d_pc_o, 32'd0);
        drive(1'b0, 32'd0, 1'b0, 1'b0);
        @(negedge clk_i);
        rst_i = 1'b1;

        // Streaming with decode always ready
        drive(1'b1, 32'h00, 1'b1, 1'b0);
        step();
        chk("str0_pc", d_pc_o, 32'h00);
        chk("str0_instr", d_instr_o, ins(32'h00));
        chk("str0_cnt", 32'(count_o), 32'd1);
        drive(1'b1, 32'h04, 1'b1, 1'b0);
        step();
        chk("str1_pc", d_pc_o, 32'h04);
        chk("str1_cnt", 32'(count_o), 32'd1);
        drive(1'b1, 32'h08, 1'b1, 1'b0);
        step();
        chk("str2_pc", d_pc_o, 32'h08);
        chk("str2_instr", d_instr_o, ins(32'h08));
        chk("str2_cnt", 32'(count_o), 32'd1);
        drive(1'b0, 32'h0, 1'b1, 1'b0);
        step();
        chk("str_drain_cnt", 32'(count_o), 32'd0);
        chk("str_drain_nop", d_instr_o, NOP);

        // Stall: decode holds off, buffer fills
        drive(1'b1, 32'h10, 1'b0, 1'b0);
        step();
        chk("stl0_pc", d_pc_o, 32'h10);
        drive(1'b1, 32'h14, 1'b0, 1'b0);
        step();
        chk("stl_cnt", 32'(count_o), 32'd2);
        chk("stl_ready", 32'(f_ready_o), 32'd0);
        chk("stl_pc", d_pc_o, 32'h10);
        drive(1'b1, 32'h99, 1'b0, 1'b0);
        step();
        chk("stl_hold_pc", d_pc_o, 32'h10);
        chk("stl_hold_cnt", 32'(count_o), 32'd2);
        drive(1'b0, 32'h0, 1'b1, 1'b0);
        chk("stl_pop0_pc", d_pc_o, 32'h10);
        step();
        chk("stl_pop1_pc", d_pc_o, 32'h14);
        chk("stl_pop1_instr", d_instr_o, ins(32'h14));
        chk("stl_pop1_cnt", 32'(count_o), 32'd1);
        step();
        chk("stl_empty", 32'(count_o), 32'd0);

        // Flush from FULL with a concurrent push of 0x18
        drive(1'b1, 32'h20, 1'b0, 1'b0);
        step();
        drive(1'b1, 32'h24, 1'b0, 1'b0);
        step();
        chk("fl_full", 32'(count_o), 32'd2);
        drive(1'b1, 32'h18, 1'b1, 1'b1);
        step();
        chk("fl_cnt", 32'(count_o), 32'd0);
        chk("fl_valid", 32'(d_valid_o), 32'd0);
        chk("fl_nop", d_instr_o, NOP);
        drive(1'b0, 32'h0, 1'b1, 1'b0);
        step();
        chk("fl_after_cnt", 32'(count_o), 32'd0);
        chk("fl_after_valid", 32'(d_valid_o), 32'd0);
        chk("fl_after_nop", d_instr_o, NOP);

        // Asynchronous reset between edges while FULL
        drive(1'b1, 32'h30, 1'b0, 1'b0);
        step();
        drive(1'b1, 32'h34, 1'b0, 1'b0);
        step();
        chk("ar_full", 32'(count_o), 32'd2);
        drive(1'b0, 32'h0, 1'b0, 1'b0);
        #2 rst_i = 1'b0;
        #1;
        chk("ar_valid", 32'(d_valid_o), 32'd0);
        chk("ar_cnt", 32'(count_o), 32'd0);
        chk("ar_nop", d_instr_o, NOP);
        chk("ar_pc", d_pc_o, 32'd0);
        chk("ar_ready", 32'(f_ready_o), 32'd1);
        @(negedge clk_i);
        rst_i = 1'b1;

        // Random traffic against a reference queue
        begin
            logic [31:0] pc;
            logic        v, r, fl, push, pop;
            pc = 32'h1000;
            q.delete();
            @(posedge clk_i);
            #1;
            for (int c = 0; c < 10000; c++) begin
                v  = ($urandom_range(3) != 0);
                r  = ($urandom_range(2) != 0);
                fl = ($urandom_range(19) == 0);
                f_valid_i = v;
                f_pc_i    = pc;
                f_instr_i = $urandom;
                d_ready_i = r;
                flush_i   = fl;
                #1;
                // Must still match the registered occupancy after inputs change
                chk("rnd_ready", 32'(f_ready_o), 32'(q.size() != 2));
                push = v && (q.size() != 2);
                pop  = r && (q.size() != 0);
                if (fl) begin
                    q.delete();
                end else begin
                    if (pop) void'(q.pop_front());
                    if (push) q.push_back({f_pc_i, f_instr_i});
                end
                if (push) pc = pc + 32'd4;
                step();
                chk("rnd_cnt", 32'(count_o), 32'(q.size()));
                chk("rnd_valid", 32'(d_valid_o), 32'(q.size() != 0));
                if (q.size() != 0) begin
                    chk("rnd_pc", d_pc_o, q[0][63:32]);
                    chk("rnd_instr", d_instr_o, q[0][31:0]);
                end else begin
                    chk("rnd_nop", d_instr_o, NOP);
                end
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
